// File: rtl/ps2_matrix.sv
// PS/2 keyboard receiver that turns scancodes into a key matrix scanned through row selects.
// Received bytes are looked up externally (map_code/map_req -> map_hit/map_row/map_col).
module ps2_matrix #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic [1:0]      ps2,
  output logic [8:0]      map_code,
  output logic            map_req,
  input  logic            map_hit,
  input  logic [3:0]      map_row,
  input  logic [3:0]      map_col,
  input  logic [ROWS-1:0] a,
  output logic [COLS-1:0] q,
  output logic            code_valid,
  output logic [7:0]      code,
  output logic            error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]        sync1, sync2;
  logic [FILTER-1:0] filt;
  logic [FILTER-1:0] filt_next;
  logic              fclk;
  logic              fall;
  logic              din;

  state_t            state, state_next;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [TW-1:0]     tcnt;
  logic              accept, fault, timeout;
  logic              rx_ok;

  logic              ext, rel, rel_l;
  logic [ROWS-1:0][COLS-1:0] key;

  // Both PS/2 lines idle high, so the synchronizer resets to ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= ps2;
      sync2 <= sync1;
    end
  end

  assign filt_next = {filt[FILTER-2:0], sync2[0]};
  assign din       = sync2[1];
  assign fall      = ce & fclk & (filt_next == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt <= '1;
      fclk <= 1'b1;
    end else if (ce) begin
      filt <= filt_next;
      if (&filt_next)
        fclk <= 1'b1;
      else if (~|filt_next)
        fclk <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fault      = 1'b0;
    timeout    = ce & ~fall & (state != IDLE) & (tcnt == TW'(TIMEOUT - 1));
    if (timeout) begin
      state_next = IDLE;
      fault      = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!din) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          if (din && (^{shreg, par_bit}))
            accept = 1'b1;
          else
            fault = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      rx_ok      <= 1'b0;
      error      <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      if (fall)
        tcnt <= '0;
      else if (ce)
        tcnt <= (state == IDLE) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE)
        bit_cnt <= '0;
      if (fall && state == DATA) begin
        shreg   <= {din, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY)
        par_bit <= din;
      rx_ok      <= accept;
      error      <= fault;
      code_valid <= rx_ok;
      if (rx_ok)
        code <= shreg;
    end
  end

  // Decode runs every clock; rel is latched so the matrix update one clock later sees it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ext      <= 1'b0;
      rel      <= 1'b0;
      rel_l    <= 1'b0;
      map_req  <= 1'b0;
      map_code <= '0;
      key      <= '0;
    end else begin
      map_req <= 1'b0;
      if (map_req && map_hit) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (map_row == 4'(r) && map_col == 4'(c))
              key[r][c] <= ~rel_l;
      end
      if (error) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (code_valid) begin
        case (code)
          8'hE0: ext <= 1'b1;
          8'hF0: rel <= 1'b1;
          8'h00, 8'hFF: begin
            ext <= 1'b0;
            rel <= 1'b0;
            key <= '0;
          end
          default: begin
            map_req  <= 1'b1;
            map_code <= {ext, code};
            rel_l    <= rel;
            ext      <= 1'b0;
            rel      <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    q = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (a[r] && key[r][c])
          q[c] = 1'b1;
  end

endmodule

// File: tb/tb_ps2_matrix.sv
// Directed bench for ps2_matrix: PS/2 frames are bit-banged in, expected codes and
// lookup keys are queued when sent and compared when the DUT pulses code_valid/map_req.
module tb_ps2_matrix;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic [1:0] ps2;
  logic [8:0] map_code;
  logic       map_req;
  logic       map_hit;
  logic [3:0] map_row;
  logic [3:0] map_col;
  logic [7:0] a;
  logic [7:0] q;
  logic       code_valid;
  logic [7:0] code;
  logic       error;

  int errors = 0;
  int checks = 0;
  int cv_count = 0;
  int err_count = 0;
  int mreq_count = 0;
  int exp_cv = 0;
  int exp_err = 0;
  int exp_mreq = 0;
  logic ce_toggle = 1'b0;
  logic [7:0] exp_codes[$];
  logic [8:0] exp_maps[$];

  ps2_matrix #(.ROWS(8), .COLS(8), .FILTER(8), .TIMEOUT(1023)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2),
    .map_code(map_code), .map_req(map_req), .map_hit(map_hit),
    .map_row(map_row), .map_col(map_col), .a(a), .q(q),
    .code_valid(code_valid), .code(code), .error(error)
  );

  always #5 clock = ~clock;

  // External scancode lookup table; 0x033 deliberately points outside the matrix.
  always_comb begin
    map_hit = 1'b0;
    map_row = 4'd0;
    map_col = 4'd0;
    case (map_code)
      9'h01C, 9'h02B: begin map_hit = 1'b1; map_row = 4'd0; map_col = 4'd1; end
      9'h175:         begin map_hit = 1'b1; map_row = 4'd6; map_col = 4'd3; end
      9'h01B:         begin map_hit = 1'b1; map_row = 4'd2; map_col = 4'd5; end
      9'h023:         begin map_hit = 1'b1; map_row = 4'd7; map_col = 4'd7; end
      9'h033:         begin map_hit = 1'b1; map_row = 4'd9; map_col = 4'd1; end
      9'h03C:         begin map_hit = 1'b1; map_row = 4'd1; map_col = 4'd0; end
      9'h04B:         begin map_hit = 1'b1; map_row = 4'd3; map_col = 4'd2; end
      default: ;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (code_valid) begin
        cv_count++;
        if (exp_codes.size() == 0)
          check_output("unexpected_code_valid", 32'(exp_codes.size()), 32'd1);
        else
          check_output("code", {24'h0, code}, {24'h0, exp_codes.pop_front()});
      end
      if (map_req) begin
        mreq_count++;
        if (exp_maps.size() == 0)
          check_output("unexpected_map_req", 32'(exp_maps.size()), 32'd1);
        else
          check_output("map_code", {23'h0, map_code}, {23'h0, exp_maps.pop_front()});
      end
      if (error)
        err_count++;
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (ce_toggle)
        ce = ~ce;
    end
  endtask

  task automatic send_bit(input logic b, input int h);
    ps2[1] = b;
    ticks(h);
    ps2[0] = 1'b0;
    ticks(h);
    ps2[0] = 1'b1;
  endtask

  task automatic apply_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int h);
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++)
      send_bit(b[i], h);
    send_bit((~^b) ^ bad_par, h);
    send_bit(~bad_stop, h);
    ps2[1] = 1'b1;
    ticks(4 * h);
  endtask

  task automatic expect_code(input logic [7:0] b);
    exp_codes.push_back(b);
    exp_cv++;
  endtask

  task automatic expect_map(input logic [8:0] m);
    exp_maps.push_back(m);
    exp_mreq++;
  endtask

  task automatic check_q(input logic [7:0] rows, input logic [7:0] exp, input string tag);
    a = rows;
    #1;
    check_output(tag, {24'h0, q}, {24'h0, exp});
  endtask

  task automatic check_counts(input string tag);
    check_output({tag, "_cv"}, cv_count, exp_cv);
    check_output({tag, "_err"}, err_count, exp_err);
    check_output({tag, "_mreq"}, mreq_count, exp_mreq);
  endtask

  initial begin
    int base;
    int k;
    reset = 1'b1;
    ce    = 1'b1;
    ps2   = 2'b11;
    a     = 8'hFF;
    ticks(3);
    check_output("reset_code", {24'h0, code}, 32'h0);
    check_output("reset_outs", {28'h0, code_valid, map_req, error, 1'b0}, 32'h0);
    check_output("reset_q", {24'h0, q}, 32'h0);
    reset = 1'b0;
    a = 8'h00;
    ticks(5);

    // Single press of 0x1C lands on row0/col1.
    expect_code(8'h1C); expect_map(9'h01C);
    apply_frame(8'h1C, 1'b0, 1'b0, 16);
    check_output("code_hold", {24'h0, code}, 32'h1C);
    check_q(8'h01, 8'h02, "press_1c");
    check_counts("press");

    // Release of the same key.
    expect_code(8'hF0); expect_code(8'h1C); expect_map(9'h01C);
    apply_frame(8'hF0, 1'b0, 1'b0, 16);
    apply_frame(8'h1C, 1'b0, 1'b0, 16);
    check_q(8'h01, 8'h00, "release_1c");
    check_counts("release");

    // Extended key.
    expect_code(8'hE0); expect_code(8'h75); expect_map(9'h175);
    apply_frame(8'hE0, 1'b0, 1'b0, 16);
    apply_frame(8'h75, 1'b0, 1'b0, 16);
    check_q(8'h40, 8'h08, "ext_175");

    // Two scancodes sharing row0/col1: last event wins.
    expect_code(8'h1B); expect_map(9'h01B);
    apply_frame(8'h1B, 1'b0, 1'b0, 16);
    check_q(8'h04, 8'h20, "press_1b");
    expect_code(8'h2B); expect_map(9'h02B);
    apply_frame(8'h2B, 1'b0, 1'b0, 16);
    check_q(8'h01, 8'h02, "press_2b");
    expect_code(8'hF0); expect_code(8'h1C); expect_map(9'h01C);
    apply_frame(8'hF0, 1'b0, 1'b0, 16);
    apply_frame(8'h1C, 1'b0, 1'b0, 16);
    check_q(8'h01, 8'h00, "shared_release");

    // Out-of-range and unmapped lookups leave the matrix alone.
    expect_code(8'h33); expect_map(9'h033);
    apply_frame(8'h33, 1'b0, 1'b0, 16);
    expect_code(8'h44); expect_map(9'h044);
    apply_frame(8'h44, 1'b0, 1'b0, 16);
    check_q(8'hFF, 8'h28, "no_change");
    check_q(8'h00, 8'h00, "no_rows");

    // Parity fault clears ext; stop fault follows.
    expect_code(8'hE0);
    apply_frame(8'hE0, 1'b0, 1'b0, 16);
    exp_err++;
    apply_frame(8'h1C, 1'b1, 1'b0, 16);
    expect_code(8'h75); expect_map(9'h075);
    apply_frame(8'h75, 1'b0, 1'b0, 16);
    exp_err++;
    apply_frame(8'h1C, 1'b0, 1'b1, 16);
    check_q(8'hFF, 8'h28, "after_faults");
    check_counts("faults");

    // Frame abandoned after four data bits must time out.
    base = err_count;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, 16);
    ps2[1] = 1'b1;
    k = 0;
    while (err_count == base && k < 2000) begin
      ticks(1);
      k++;
    end
    exp_err++;
    check_output("timeout_error", err_count - base, 32'd1);
    expect_code(8'h23); expect_map(9'h023);
    apply_frame(8'h23, 1'b0, 1'b0, 16);
    check_q(8'h80, 8'h80, "after_timeout");

    // Frame received with ce running at half rate.
    ce_toggle = 1'b1;
    expect_code(8'h3C); expect_map(9'h03C);
    apply_frame(8'h3C, 1'b0, 1'b0, 40);
    ce_toggle = 1'b0;
    ce = 1'b1;
    ticks(4);
    check_q(8'h02, 8'h01, "slow_ce");

    // One-sample clock glitch while data is low must not start a frame.
    ps2[1] = 1'b0;
    ticks(4);
    ps2[0] = 1'b0;
    ticks(1);
    ps2[0] = 1'b1;
    ticks(20);
    ps2[1] = 1'b1;
    ticks(20);
    expect_code(8'h4B); expect_map(9'h04B);
    apply_frame(8'h4B, 1'b0, 1'b0, 16);
    check_q(8'hFF, 8'hAD, "after_glitch");
    check_counts("glitch");

    // Overrun wipes the matrix.
    expect_code(8'hFF);
    apply_frame(8'hFF, 1'b0, 1'b0, 16);
    check_q(8'hFF, 8'h00, "overrun");

    // Reset in the middle of a frame.
    expect_code(8'h1C); expect_map(9'h01C);
    apply_frame(8'h1C, 1'b0, 1'b0, 16);
    check_q(8'h01, 8'h02, "pre_reset");
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++)
      send_bit(1'b0, 16);
    reset = 1'b1;
    ps2 = 2'b11;
    ticks(2);
    check_q(8'hFF, 8'h00, "midframe_reset_q");
    check_output("midframe_reset_code", {24'h0, code}, 32'h0);
    check_output("midframe_reset_outs", {29'h0, code_valid, map_req, error}, 32'h0);
    reset = 1'b0;
    ticks(5);
    expect_code(8'h1C); expect_map(9'h01C);
    apply_frame(8'h1C, 1'b0, 1'b0, 16);
    check_q(8'h01, 8'h02, "post_reset");
    check_counts("final");
    check_output("codes_left", 32'(exp_codes.size()), 32'd0);
    check_output("maps_left", 32'(exp_maps.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
